// File: rtl/counter_slot_arbiter.sv
// rtl/counter_slot_arbiter.sv - round-robin arbiter lending one limit counter to N_REQ requesters
// A slot runs the shared counter from 0 to the limit captured at grant time, then pulses done.
module counter_slot_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [WIDTH-1:0] limit,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic [N_REQ-1:0] done
);

   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic [IDX_W-1:0] rr_next;
   int               j;

   assign busy    = (state_q == S_RUN);
   assign ovf     = busy && (count_q == lim_q);
   assign grant   = grant_q;
   assign gnt_idx = gnt_idx_q;
   assign count   = count_q;
   assign done    = done_q;
   assign rr_next = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

   // Scan from the far end back toward rr_ptr so the nearest set request wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr_q) + k) % N_REQ;
         if (req[SEL_W'(j)]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(j);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      done_d    = '0;
      gnt_idx_d = gnt_idx_q;
      rr_ptr_d  = rr_ptr_q;
      count_d   = count_q;
      lim_d     = lim_q;
      case (state_q)
         S_RUN: begin
            if (ovf) begin
               state_d  = S_DONE;
               grant_d  = '0;
               done_d   = N_REQ'(1) << gnt_idx_q;
               count_d  = '0;
               rr_ptr_d = rr_next;
            end else if (!req[SEL_W'(gnt_idx_q)]) begin
               state_d  = S_IDLE;
               grant_d  = '0;
               count_d  = '0;
               rr_ptr_d = rr_next;
            end else begin
               count_d = WIDTH'({1'b0, count_q} + 1'b1);
            end
         end
         default: begin
            if (pick_found) begin
               state_d   = S_RUN;
               grant_d   = N_REQ'(1) << pick_idx;
               gnt_idx_d = pick_idx;
               lim_d     = limit;
               count_d   = '0;
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
               count_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         done_q    <= '0;
         gnt_idx_q <= '0;
         rr_ptr_q  <= '0;
         count_q   <= '0;
         lim_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         gnt_idx_q <= gnt_idx_d;
         rr_ptr_q  <= rr_ptr_d;
         count_q   <= count_d;
         lim_q     <= lim_d;
      end
   end

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// tb/tb_counter_slot_arbiter.sv - directed self-checking bench for counter_slot_arbiter
module tb_counter_slot_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] limit;
   logic [3:0]  grant;
   logic [1:0]  gnt_idx;
   logic        busy;
   logic [15:0] count;
   logic        ovf;
   logic [3:0]  done;

   int n_checks;
   int n_fail;

   counter_slot_arbiter #(.N_REQ(4), .WIDTH(16), .IDX_W(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .limit   (limit),
      .grant   (grant),
      .gnt_idx (gnt_idx),
      .busy    (busy),
      .count   (count),
      .ovf     (ovf),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(1);
      rst = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      req      = 4'b1111;
      limit    = 16'd0;

      // reset held with every requester active
      for (int c = 0; c < 3; c++) begin
         step(1);
         check("rst_grant", 32'(grant), 32'h0);
         check("rst_busy",  32'(busy),  32'h0);
         check("rst_count", 32'(count), 32'h0);
         check("rst_done",  32'(done),  32'h0);
      end
      check("rst_idx", 32'(gnt_idx), 32'h0);
      rst = 1'b1;
      req = 4'b0000;
      step(1);
      check("idle_grant", 32'(grant), 32'h0);

      // single slot, limit 25
      req   = 4'b0001;
      limit = 16'd25;
      step(1);
      check("s_grant", 32'(grant), 32'h1);
      check("s_count0", 32'(count), 32'h0);
      check("s_busy", 32'(busy), 32'h1);
      step(24);
      check("s_count24", 32'(count), 32'd24);
      check("s_noovf", 32'(ovf), 32'h0);
      step(1);
      check("s_ovf", 32'(ovf), 32'h1);
      step(1);
      check("s_done", 32'(done), 32'h1);
      check("s_gap", 32'(grant), 32'h0);
      check("s_idle_busy", 32'(busy), 32'h0);
      step(1);
      check("s_regrant", 32'(grant), 32'h1);
      check("s_done_clr", 32'(done), 32'h0);

      // round robin 0,1,3,0 with limit 2
      req = 4'b0000;
      do_reset();
      req   = 4'b1011;
      limit = 16'd2;
      step(1);
      begin
         logic [3:0] order [4];
         order[0] = 4'b0001;
         order[1] = 4'b0010;
         order[2] = 4'b1000;
         order[3] = 4'b0001;
         for (int s = 0; s < 4; s++) begin
            check("rr_grant", 32'(grant), 32'(order[s]));
            step(3);
            check("rr_gap", 32'(grant), 32'h0);
            check("rr_done", 32'(done), 32'(order[s]));
            step(1);
         end
      end

      // abort at count 10; limit change during RUN ignored
      req = 4'b0000;
      do_reset();
      req   = 4'b0100;
      limit = 16'd100;
      step(1);
      check("ab_grant", 32'(grant), 32'h4);
      check("ab_idx", 32'(gnt_idx), 32'h2);
      limit = 16'd5;
      step(10);
      check("ab_count10", 32'(count), 32'd10);
      check("ab_limfreeze", 32'(ovf), 32'h0);
      req = 4'b1000;
      step(1);
      check("ab_grant0", 32'(grant), 32'h0);
      check("ab_nodone", 32'(done), 32'h0);
      check("ab_busy", 32'(busy), 32'h0);
      check("ab_count", 32'(count), 32'h0);
      step(1);
      check("ab_next", 32'(grant), 32'h8);
      check("ab_next_idx", 32'(gnt_idx), 32'h3);

      // limit 0: one-cycle slot
      req = 4'b0000;
      do_reset();
      req   = 4'b0001;
      limit = 16'd0;
      step(1);
      check("l0_busy", 32'(busy), 32'h1);
      check("l0_ovf", 32'(ovf), 32'h1);
      step(1);
      check("l0_done", 32'(done), 32'h1);
      check("l0_busy_off", 32'(busy), 32'h0);

      // requester drops on the ovf cycle
      req = 4'b0000;
      do_reset();
      req   = 4'b0010;
      limit = 16'd3;
      step(1);
      check("dr_grant", 32'(grant), 32'h2);
      step(3);
      check("dr_ovf", 32'(ovf), 32'h1);
      req = 4'b0000;
      step(1);
      check("dr_done", 32'(done), 32'h2);
      check("dr_grant0", 32'(grant), 32'h0);

      // full-range limit, no wrap
      do_reset();
      req   = 4'b0001;
      limit = 16'hFFFF;
      step(1);
      limit = 16'd0;
      check("ff_count0", 32'(count), 32'h0);
      step(65534);
      check("ff_countfffe", 32'(count), 32'hFFFE);
      check("ff_noovf", 32'(ovf), 32'h0);
      step(1);
      check("ff_countffff", 32'(count), 32'hFFFF);
      check("ff_ovf", 32'(ovf), 32'h1);
      step(1);
      check("ff_done", 32'(done), 32'h1);
      check("ff_count_clr", 32'(count), 32'h0);

      // reset mid-RUN restarts arbitration at index 0
      req = 4'b0000;
      do_reset();
      req   = 4'b0100;
      limit = 16'd0;
      step(1);
      limit = 16'd50;
      step(1);
      check("mr_done", 32'(done), 32'h4);
      step(1);
      check("mr_grant", 32'(grant), 32'h4);
      step(7);
      check("mr_count7", 32'(count), 32'd7);
      rst = 1'b0;
      step(1);
      check("mr_grant0", 32'(grant), 32'h0);
      check("mr_busy0", 32'(busy), 32'h0);
      check("mr_count0", 32'(count), 32'h0);
      check("mr_done0", 32'(done), 32'h0);
      check("mr_idx0", 32'(gnt_idx), 32'h0);
      rst = 1'b1;
      req = 4'b1111;
      step(1);
      check("mr_restart", 32'(grant), 32'h1);
      check("mr_restart_idx", 32'(gnt_idx), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
